instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instruction_fetch.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP encoding and PC helpers.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Word-align a PC by clearing the byte-offset bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage : fetch_pkg

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: requests a word, holds it for the
// decoder until consumed, and discards in-flight responses made stale by a redirect.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic            decode_enable
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] instruction_nxt;
    logic [XLEN-1:0] instr_pc_nxt;
    logic            instr_valid_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_REQ;
            pc          <= align_pc(RESET_PC);
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instruction_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

    // Next-state and datapath update; a redirect overrides the normal flow.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instruction_nxt = instruction;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;

        unique case (state)
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    instruction_nxt = mem_rsp_data;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    state_nxt       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    pc_nxt          = pc + PC_STEP;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (mem_rsp_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase

        if (redirect_valid) begin
            pc_nxt          = align_pc(redirect_pc);
            instr_valid_nxt = 1'b0;
            instruction_nxt = instruction;
            instr_pc_nxt    = instr_pc;
            unique case (state)
                ST_REQ:   state_nxt = mem_req_ready ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_nxt = mem_rsp_valid ? ST_REQ : ST_DRAIN;
                ST_HOLD:  state_nxt = ST_REQ;
                ST_DRAIN: state_nxt = mem_rsp_valid ? ST_REQ : ST_DRAIN;
                default:  state_nxt = ST_REQ;
            endcase
        end
    end

    // Request is a pure state decode, squashed while reset is held.
    assign mem_req_valid = (state == ST_REQ) && rst_n;
    assign mem_req_addr  = pc;
    assign decode_enable = instr_valid & ~stall;

endmodule : instruction_fetch
